// File: rtl/dmem_arbiter.sv
// Single-port DMEM arbiter: the execute stage normally owns the port, the external
// requester is served in idle cycles or, after STARVE_LIMIT denials, by a one-cycle forced stall.
module dmem_arbiter #(
    parameter int DMEM_ADDR_WIDTH = 12,
    parameter int DMEM_WORD_WIDTH = 16,
    parameter int STARVE_LIMIT    = 8,
    parameter int CNT_WIDTH       = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_ex_load,
    input  logic                       in_ex_store,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_ex_rd_addr,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_ex_wr_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] in_ex_wr_word,
    input  logic                       in_ext_req,
    input  logic                       in_ext_we,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_ext_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] in_ext_wr_word,
    output logic                       out_ext_gnt,
    output logic                       out_ext_rd_valid,
    output logic [DMEM_WORD_WIDTH-1:0] out_ext_rd_word,
    output logic                       out_stall,
    output logic                       out_dmem_en,
    output logic                       out_dmem_we,
    output logic [DMEM_ADDR_WIDTH-1:0] out_dmem_addr,
    output logic [DMEM_WORD_WIDTH-1:0] out_dmem_wr_word,
    input  logic [DMEM_WORD_WIDTH-1:0] in_dmem_rd_word
);

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_FORCED = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STARVE_LIMIT - 1);

    state_t                     state_r;
    state_t                     state_nxt_s;
    logic [CNT_WIDTH-1:0]       starve_cnt_r;
    logic [CNT_WIDTH-1:0]       starve_cnt_nxt_s;
    logic                       ext_rd_pend_r;

    logic                       ex_access_s;
    logic                       gnt_s;
    logic                       stall_s;
    logic                       en_s;
    logic                       we_s;
    logic [DMEM_ADDR_WIDTH-1:0] addr_s;
    logic [DMEM_WORD_WIDTH-1:0] wr_word_s;

    assign ex_access_s = in_ex_load | in_ex_store;

    // Next-state, starvation counter and DMEM port steering
    always_comb begin
        state_nxt_s      = ST_NORMAL;
        starve_cnt_nxt_s = {CNT_WIDTH{1'b0}};
        gnt_s            = 1'b0;
        stall_s          = 1'b0;
        en_s             = 1'b0;
        we_s             = 1'b0;
        addr_s           = {DMEM_ADDR_WIDTH{1'b0}};
        wr_word_s        = {DMEM_WORD_WIDTH{1'b0}};
        case (state_r)
            ST_NORMAL: begin
                if (ex_access_s) begin
                    // A store takes precedence over a simultaneous (illegal) load
                    en_s = 1'b1;
                    we_s = in_ex_store;
                    if (in_ex_store) begin
                        addr_s    = in_ex_wr_addr;
                        wr_word_s = in_ex_wr_word;
                    end else begin
                        addr_s    = in_ex_rd_addr;
                        wr_word_s = {DMEM_WORD_WIDTH{1'b0}};
                    end
                    if (in_ext_req) begin
                        if (starve_cnt_r == CNT_LAST) begin
                            state_nxt_s      = ST_FORCED;
                            starve_cnt_nxt_s = starve_cnt_r;
                        end else begin
                            state_nxt_s      = ST_NORMAL;
                            starve_cnt_nxt_s = starve_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        starve_cnt_nxt_s = {CNT_WIDTH{1'b0}};
                    end
                end else if (in_ext_req) begin
                    gnt_s  = 1'b1;
                    en_s   = 1'b1;
                    we_s   = in_ext_we;
                    addr_s = in_ext_addr;
                    if (in_ext_we) begin
                        wr_word_s = in_ext_wr_word;
                    end else begin
                        wr_word_s = {DMEM_WORD_WIDTH{1'b0}};
                    end
                end else begin
                    starve_cnt_nxt_s = {CNT_WIDTH{1'b0}};
                end
            end
            ST_FORCED: begin
                // EX is frozen this cycle and re-presents its access afterwards
                stall_s = 1'b1;
                if (in_ext_req) begin
                    gnt_s  = 1'b1;
                    en_s   = 1'b1;
                    we_s   = in_ext_we;
                    addr_s = in_ext_addr;
                    if (in_ext_we) begin
                        wr_word_s = in_ext_wr_word;
                    end else begin
                        wr_word_s = {DMEM_WORD_WIDTH{1'b0}};
                    end
                end else begin
                    gnt_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = ST_NORMAL;
            end
        endcase
    end

    // State, starvation counter and pending external read
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_NORMAL;
            starve_cnt_r  <= {CNT_WIDTH{1'b0}};
            ext_rd_pend_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            starve_cnt_r  <= starve_cnt_nxt_s;
            ext_rd_pend_r <= gnt_s & ~in_ext_we;
        end
    end

    // Outputs are combinational, so they are held at zero while reset is asserted
    assign out_ext_gnt      = reset & gnt_s;
    assign out_stall        = reset & stall_s;
    assign out_dmem_en      = reset & en_s;
    assign out_dmem_we      = reset & we_s;
    assign out_dmem_addr    = reset ? addr_s : {DMEM_ADDR_WIDTH{1'b0}};
    assign out_dmem_wr_word = reset ? wr_word_s : {DMEM_WORD_WIDTH{1'b0}};
    assign out_ext_rd_valid = reset & ext_rd_pend_r;
    assign out_ext_rd_word  = (reset & ext_rd_pend_r) ? in_dmem_rd_word : {DMEM_WORD_WIDTH{1'b0}};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: inputs change 1 time unit after a rising edge,
// outputs are checked 4 time units after the edge, well before the next one.
module tb_dmem_arbiter;

    logic        clock;
    logic        reset;
    logic        in_ex_load;
    logic        in_ex_store;
    logic [11:0] in_ex_rd_addr;
    logic [11:0] in_ex_wr_addr;
    logic [15:0] in_ex_wr_word;
    logic        in_ext_req;
    logic        in_ext_we;
    logic [11:0] in_ext_addr;
    logic [15:0] in_ext_wr_word;
    logic        out_ext_gnt;
    logic        out_ext_rd_valid;
    logic [15:0] out_ext_rd_word;
    logic        out_stall;
    logic        out_dmem_en;
    logic        out_dmem_we;
    logic [11:0] out_dmem_addr;
    logic [15:0] out_dmem_wr_word;
    logic [15:0] in_dmem_rd_word;

    int checks;
    int errors;

    dmem_arbiter #(
        .DMEM_ADDR_WIDTH(12),
        .DMEM_WORD_WIDTH(16),
        .STARVE_LIMIT   (8),
        .CNT_WIDTH      (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .in_ex_load      (in_ex_load),
        .in_ex_store     (in_ex_store),
        .in_ex_rd_addr   (in_ex_rd_addr),
        .in_ex_wr_addr   (in_ex_wr_addr),
        .in_ex_wr_word   (in_ex_wr_word),
        .in_ext_req      (in_ext_req),
        .in_ext_we       (in_ext_we),
        .in_ext_addr     (in_ext_addr),
        .in_ext_wr_word  (in_ext_wr_word),
        .out_ext_gnt     (out_ext_gnt),
        .out_ext_rd_valid(out_ext_rd_valid),
        .out_ext_rd_word (out_ext_rd_word),
        .out_stall       (out_stall),
        .out_dmem_en     (out_dmem_en),
        .out_dmem_we     (out_dmem_we),
        .out_dmem_addr   (out_dmem_addr),
        .out_dmem_wr_word(out_dmem_wr_word),
        .in_dmem_rd_word (in_dmem_rd_word)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        in_ex_load      = 1'b0;
        in_ex_store     = 1'b0;
        in_ex_rd_addr   = 12'h000;
        in_ex_wr_addr   = 12'h000;
        in_ex_wr_word   = 16'h0000;
        in_ext_req      = 1'b0;
        in_ext_we       = 1'b0;
        in_ext_addr     = 12'h000;
        in_ext_wr_word  = 16'h0000;
        in_dmem_rd_word = 16'h0000;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Reset asserted with every input active
        reset           = 1'b0;
        in_ex_load      = 1'b1;
        in_ex_store     = 1'b1;
        in_ex_rd_addr   = 12'hFFF;
        in_ex_wr_addr   = 12'hABC;
        in_ex_wr_word   = 16'hFFFF;
        in_ext_req      = 1'b1;
        in_ext_we       = 1'b0;
        in_ext_addr     = 12'h555;
        in_ext_wr_word  = 16'hAAAA;
        in_dmem_rd_word = 16'hDEAD;
        next_cycle();
        next_cycle();
        #3;
        chk("rst_gnt",      32'(out_ext_gnt),      32'h0);
        chk("rst_rd_valid", 32'(out_ext_rd_valid), 32'h0);
        chk("rst_rd_word",  32'(out_ext_rd_word),  32'h0);
        chk("rst_stall",    32'(out_stall),        32'h0);
        chk("rst_en",       32'(out_dmem_en),      32'h0);
        chk("rst_we",       32'(out_dmem_we),      32'h0);
        chk("rst_addr",     32'(out_dmem_addr),    32'h0);
        chk("rst_wr_word",  32'(out_dmem_wr_word), 32'h0);

        // Release, idle
        next_cycle();
        idle_inputs();
        reset = 1'b1;
        #3;
        chk("idle_en",  32'(out_dmem_en), 32'h0);
        chk("idle_cnt", 32'(dut.starve_cnt_r), 32'h0);

        // EX store, no external request
        next_cycle();
        in_ex_store   = 1'b1;
        in_ex_wr_addr = 12'h010;
        in_ex_wr_word = 16'hBEEF;
        #3;
        chk("st_en",    32'(out_dmem_en),      32'h1);
        chk("st_we",    32'(out_dmem_we),      32'h1);
        chk("st_addr",  32'(out_dmem_addr),    32'h010);
        chk("st_word",  32'(out_dmem_wr_word), 32'hBEEF);
        chk("st_gnt",   32'(out_ext_gnt),      32'h0);
        chk("st_stall", 32'(out_stall),        32'h0);

        // External read in an idle cycle
        next_cycle();
        idle_inputs();
        in_ext_req  = 1'b1;
        in_ext_addr = 12'h020;
        #3;
        chk("xr_gnt",   32'(out_ext_gnt),      32'h1);
        chk("xr_en",    32'(out_dmem_en),      32'h1);
        chk("xr_we",    32'(out_dmem_we),      32'h0);
        chk("xr_addr",  32'(out_dmem_addr),    32'h020);
        chk("xr_word",  32'(out_dmem_wr_word), 32'h0);
        chk("xr_valid0", 32'(out_ext_rd_valid), 32'h0);
        next_cycle();
        in_ext_req      = 1'b0;
        in_dmem_rd_word = 16'h1234;
        #3;
        chk("xr_valid1", 32'(out_ext_rd_valid), 32'h1);
        chk("xr_rdword", 32'(out_ext_rd_word),  32'h1234);
        chk("xr_en1",    32'(out_dmem_en),      32'h0);
        next_cycle();
        #3;
        chk("xr_valid2", 32'(out_ext_rd_valid), 32'h0);
        chk("xr_rdword2", 32'(out_ext_rd_word), 32'h0);

        // EX load every cycle against a continuous external write
        next_cycle();
        idle_inputs();
        in_ex_load     = 1'b1;
        in_ex_rd_addr  = 12'h030;
        in_ext_req     = 1'b1;
        in_ext_we      = 1'b1;
        in_ext_addr    = 12'h040;
        in_ext_wr_word = 16'h5A5A;
        for (int i = 0; i < 8; i++) begin
            #3;
            chk("sv_gnt",   32'(out_ext_gnt),   32'h0);
            chk("sv_stall", 32'(out_stall),     32'h0);
            chk("sv_addr",  32'(out_dmem_addr), 32'h030);
            chk("sv_we",    32'(out_dmem_we),   32'h0);
            chk("sv_cnt",   32'(dut.starve_cnt_r), 32'(i));
            next_cycle();
        end
        #3;
        chk("fc_stall", 32'(out_stall),        32'h1);
        chk("fc_gnt",   32'(out_ext_gnt),      32'h1);
        chk("fc_en",    32'(out_dmem_en),      32'h1);
        chk("fc_we",    32'(out_dmem_we),      32'h1);
        chk("fc_addr",  32'(out_dmem_addr),    32'h040);
        chk("fc_word",  32'(out_dmem_wr_word), 32'h5A5A);
        chk("fc_cnt",   32'(dut.starve_cnt_r), 32'h7);
        next_cycle();
        in_ext_req = 1'b0;
        #3;
        chk("af_stall", 32'(out_stall),        32'h0);
        chk("af_en",    32'(out_dmem_en),      32'h1);
        chk("af_addr",  32'(out_dmem_addr),    32'h030);
        chk("af_gnt",   32'(out_ext_gnt),      32'h0);
        chk("af_valid", 32'(out_ext_rd_valid), 32'h0);
        chk("af_cnt",   32'(dut.starve_cnt_r), 32'h0);

        // External request withdrawn before grant clears the counter
        next_cycle();
        in_ext_req = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        #3;
        chk("wd_cnt3", 32'(dut.starve_cnt_r), 32'h3);
        next_cycle();
        in_ext_req = 1'b0;
        next_cycle();
        #3;
        chk("wd_cnt0", 32'(dut.starve_cnt_r), 32'h0);

        // Load and store together: store wins
        next_cycle();
        idle_inputs();
        in_ex_load    = 1'b1;
        in_ex_store   = 1'b1;
        in_ex_rd_addr = 12'h001;
        in_ex_wr_addr = 12'h002;
        in_ex_wr_word = 16'h0077;
        #3;
        chk("ls_we",   32'(out_dmem_we),      32'h1);
        chk("ls_addr", 32'(out_dmem_addr),    32'h002);
        chk("ls_word", 32'(out_dmem_wr_word), 32'h0077);

        // External read granted, then reset before the next edge
        next_cycle();
        idle_inputs();
        in_ext_req      = 1'b1;
        in_ext_addr     = 12'h0F0;
        in_dmem_rd_word = 16'hCAFE;
        #3;
        chk("rr_gnt", 32'(out_ext_gnt), 32'h1);
        reset = 1'b0;
        #1;
        chk("rr_gnt_rst", 32'(out_ext_gnt), 32'h0);
        chk("rr_en_rst",  32'(out_dmem_en), 32'h0);
        next_cycle();
        in_ext_req = 1'b0;
        reset      = 1'b1;
        #3;
        chk("rr_valid", 32'(out_ext_rd_valid), 32'h0);
        chk("rr_word",  32'(out_ext_rd_word),  32'h0);
        chk("rr_state", 32'(dut.state_r),      32'h0);
        chk("rr_cnt",   32'(dut.starve_cnt_r), 32'h0);
        next_cycle();
        #3;
        chk("rr_valid2", 32'(out_ext_rd_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
